riscv_issue_arb: RTL and testbench
==================================

Name: riscv_issue_arb

Overview:
- Round-robin issue scheduler that shares the single riscv instruction datapath between NUM_REQ instruction sources.
- Selects one requester per cycle and drives the core's rs0/rs1/rd/opcode/valid inputs from a registered output stage.
- Blocks further issue while a load (opcode 0) is outstanding, until the core's data_valid returns or a timeout expires.
- Sits directly in front of riscv; its core_* outputs connect to the core's instruction inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- REG_WIDTH, 5, register specifier width; matches the core.
- OP_WIDTH, 7, opcode width; matches the core.
- TIMEOUT, 15, maximum LOAD_WAIT cycles before abandoning a load (1..255).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester instruction valid; held until granted.
- req_rs0  in  NUM_REQ*REG_WIDTH  packed rs0 fields; requester i at [i*REG_WIDTH +: REG_WIDTH].
- req_rs1  in  NUM_REQ*REG_WIDTH  packed rs1 fields.
- req_rd  in  NUM_REQ*REG_WIDTH  packed rd fields.
- req_opcode  in  NUM_REQ*OP_WIDTH  packed opcodes.
- req_grant  out  NUM_REQ  one-hot, combinational; instruction accepted this cycle.
- core_valid  out  1  to core valid.
- core_rs0 / core_rs1 / core_rd  out  REG_WIDTH each  to core.
- core_opcode  out  OP_WIDTH  to core.
- core_data_valid  in  1  load data return from memory; also fed to the core.
- busy  out  1  high while in LOAD_WAIT.
- timeout_err  out  1  sticky; set on load timeout.

Behaviour:
- Reset: all outputs 0; state IDLE; rr_ptr=0; wait_cnt=0; timeout_err=0. Reset asserted in LOAD_WAIT aborts the load and returns to IDLE.
- States: IDLE, LOAD_WAIT.
- Grant (IDLE only): search req_valid starting at rr_ptr, wrapping modulo NUM_REQ; the first set bit wins and req_grant is that one-hot bit. No requests -> req_grant=0.
- Pointer update: on a grant to i, rr_ptr <= (i+1) mod NUM_REQ; otherwise rr_ptr holds.
- Issue latency: 1 cycle. Grant in cycle T -> core_valid=1 and the winner's fields on core_* in T+1. With no grant, core_valid=0 and core_* fields = 0 next cycle.
- Back-to-back: one issue per cycle is allowed while in IDLE.
- Load issue: granted opcode == 0 -> state <= LOAD_WAIT and wait_cnt <= 0 at the same edge.
- LOAD_WAIT: req_grant=0; busy=1; wait_cnt increments each cycle.
  - core_data_valid=1 -> IDLE next cycle; grants resume in the cycle after.
  - wait_cnt == TIMEOUT-1 without data -> timeout_err <= 1 and IDLE.
  - core_data_valid and the timeout in the same cycle: data wins, no error.
- core_data_valid while in IDLE: ignored.
- timeout_err: cleared only by reset.
- wait_cnt width: $clog2(TIMEOUT+1).

Optional Feature:
- Macro: RISCV_ISSUE_ARB_STATS_EN.
- Defined: adds outputs issue_cnt (16-bit) and stall_cnt (16-bit).
  - issue_cnt increments per grant.
  - stall_cnt increments per cycle with any req_valid=1 and no grant.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package riscv_arb_pkg:
  - arb_state_e enum {IDLE, LOAD_WAIT}.
  - Localparam LOAD_OPCODE = 0.
  - Default width constants REG_WIDTH and OP_WIDTH.
- Sub-module rr_arbiter (NUM_REQ parameter):
  - Inputs: req, ptr, enable.
  - Outputs: one-hot grant and binary index.
  - Purely combinational; the pointer register stays in riscv_issue_arb.

Test Plan:
- Reset, then all req_valid=4'b1111, all opcodes nonzero -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles; core_valid=1 from the second cycle.
- Only req 2 valid with opcode 7'h13, rs0=3, rs1=4, rd=5 -> req_grant=0100 in T; core_* = 3/4/5/13 with core_valid=1 in T+1; core_valid=0 in T+2 once the request drops.
- Req 1 issues opcode 0 while req 3 is pending -> busy=1, no grants; core_data_valid pulsed 4 cycles later -> busy=0 next cycle; req 3 granted the cycle after.
- Load issued with TIMEOUT=15 and no core_data_valid -> after 15 LOAD_WAIT cycles timeout_err=1 and return to IDLE; next request granted; timeout_err stays 1.
- Reset asserted mid-LOAD_WAIT -> all outputs 0 immediately; after release, req 0 granted first (rr_ptr=0).
- With RISCV_ISSUE_ARB_STATS_EN: 3 grants plus 5 blocked cycles during a load -> issue_cnt=3, stall_cnt=5.

Source files
------------

// File: rtl/riscv_issue_arb_pkg.sv
// riscv_arb_pkg
// Shared types and constants for the riscv issue arbiter slice.
//   arb_state_e : scheduler states (IDLE, LOAD_WAIT)
//   LOAD_OPCODE : opcode that marks a load and blocks further issue
//   REG_WIDTH   : default register specifier width (matches the core)
//   OP_WIDTH    : default opcode width (matches the core)
package riscv_arb_pkg;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } arb_state_e;

    localparam int LOAD_OPCODE = 0;
    localparam int REG_WIDTH   = 5;
    localparam int OP_WIDTH    = 7;

endpackage

// File: rtl/riscv_issue_arb_if.sv
// riscv_issue_arb_if
// Bundles the requester-side and core-side buses of the issue arbiter.
//   req_valid / req_rs0 / req_rs1 / req_rd / req_opcode : packed per-requester
//       instruction fields, requester i at [i*W +: W]
//   req_grant        : one-hot grant back to the requesters
//   core_valid / core_rs0 / core_rs1 / core_rd / core_opcode : registered
//       instruction stage toward the core
//   core_data_valid  : load data return from memory
// Modports:
//   master : requesters + memory side (drives requests and data return)
//   slave  : the arbiter
interface riscv_issue_arb_if #(
    parameter int NUM_REQ   = 4,
    parameter int REG_WIDTH = riscv_arb_pkg::REG_WIDTH,
    parameter int OP_WIDTH  = riscv_arb_pkg::OP_WIDTH
);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*REG_WIDTH-1:0] req_rs0;
    logic [NUM_REQ*REG_WIDTH-1:0] req_rs1;
    logic [NUM_REQ*REG_WIDTH-1:0] req_rd;
    logic [NUM_REQ*OP_WIDTH-1:0]  req_opcode;
    logic [NUM_REQ-1:0]           req_grant;

    logic                         core_valid;
    logic [REG_WIDTH-1:0]         core_rs0;
    logic [REG_WIDTH-1:0]         core_rs1;
    logic [REG_WIDTH-1:0]         core_rd;
    logic [OP_WIDTH-1:0]          core_opcode;
    logic                         core_data_valid;

    modport master (
        output req_valid, req_rs0, req_rs1, req_rd, req_opcode, core_data_valid,
        input  req_grant, core_valid, core_rs0, core_rs1, core_rd, core_opcode
    );

    modport slave (
        input  req_valid, req_rs0, req_rs1, req_rd, req_opcode, core_data_valid,
        output req_grant, core_valid, core_rs0, core_rs1, core_rd, core_opcode
    );

endinterface

// File: rtl/riscv_issue_arb_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin selector.
//   req    in  NUM_REQ  request vector
//   ptr    in  IDX_W    highest-priority position for this cycle
//   enable in  1        gates all grants when low
//   grant  out NUM_REQ  one-hot winner (0 when nothing selected)
//   idx    out IDX_W    binary index of the winner (0 when nothing selected)
// The priority pointer register lives in the parent.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic             found;
    logic [IDX_W-1:0] pos;

    // Walk the request vector starting at ptr, wrapping modulo NUM_REQ;
    // the first set bit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = IDX_W'((32'(ptr) + k) % NUM_REQ);
            if (enable && !found && req[pos]) begin
                grant[pos] = 1'b1;
                idx        = pos;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/riscv_issue_arb.sv
// riscv_issue_arb
// Round-robin issue scheduler sharing one riscv instruction datapath between
// NUM_REQ instruction sources. One requester is granted per cycle (IDLE only)
// and its fields appear on the registered core_* stage the following cycle.
// Issuing a load (opcode LOAD_OPCODE) blocks further grants until
// core_data_valid returns or TIMEOUT LOAD_WAIT cycles elapse.
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-high reset
//   bus          slave modport of riscv_issue_arb_if (requests, grant,
//                core instruction stage, core_data_valid)
//   busy         out  high while waiting for load data
//   timeout_err  out  sticky load-timeout flag, cleared only by reset
//   issue_cnt    out  16-bit saturating grant count   (RISCV_ISSUE_ARB_STATS_EN)
//   stall_cnt    out  16-bit saturating blocked-cycle count (RISCV_ISSUE_ARB_STATS_EN)
// Optional feature macro: RISCV_ISSUE_ARB_STATS_EN
module riscv_issue_arb #(
    parameter int NUM_REQ   = 4,
    parameter int REG_WIDTH = riscv_arb_pkg::REG_WIDTH,
    parameter int OP_WIDTH  = riscv_arb_pkg::OP_WIDTH,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    riscv_issue_arb_if.slave     bus,
    output logic                 busy,
    output logic                 timeout_err
`ifdef RISCV_ISSUE_ARB_STATS_EN
    ,
    output logic [15:0]          issue_cnt,
    output logic [15:0]          stall_cnt
`endif
);

    import riscv_arb_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e           state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [CNT_W-1:0]     wait_cnt;

    logic [NUM_REQ-1:0]   grant;
    logic [IDX_W-1:0]     win_idx;
    logic                 any_grant;
    logic                 win_is_load;
    logic                 arb_enable;

    logic [REG_WIDTH-1:0] rs0_a [NUM_REQ];
    logic [REG_WIDTH-1:0] rs1_a [NUM_REQ];
    logic [REG_WIDTH-1:0] rd_a  [NUM_REQ];
    logic [OP_WIDTH-1:0]  op_a  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign rs0_a[g] = bus.req_rs0[g*REG_WIDTH +: REG_WIDTH];
        assign rs1_a[g] = bus.req_rs1[g*REG_WIDTH +: REG_WIDTH];
        assign rd_a[g]  = bus.req_rd[g*REG_WIDTH +: REG_WIDTH];
        assign op_a[g]  = bus.req_opcode[g*OP_WIDTH +: OP_WIDTH];
    end

    // Reset also suppresses the combinational grant so every output reads 0
    // while reset is held.
    assign arb_enable = (state == IDLE) && !reset;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req    (bus.req_valid),
        .ptr    (rr_ptr),
        .enable (arb_enable),
        .grant  (grant),
        .idx    (win_idx)
    );

    assign bus.req_grant = grant;
    assign any_grant     = |grant;
    assign win_is_load   = (op_a[win_idx] == OP_WIDTH'(LOAD_OPCODE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            wait_cnt        <= '0;
            busy            <= 1'b0;
            timeout_err     <= 1'b0;
            bus.core_valid  <= 1'b0;
            bus.core_rs0    <= '0;
            bus.core_rs1    <= '0;
            bus.core_rd     <= '0;
            bus.core_opcode <= '0;
        end else begin
            // Output stage: winner's fields one cycle after the grant,
            // zeros when nothing was granted.
            bus.core_valid  <= any_grant;
            bus.core_rs0    <= any_grant ? rs0_a[win_idx] : '0;
            bus.core_rs1    <= any_grant ? rs1_a[win_idx] : '0;
            bus.core_rd     <= any_grant ? rd_a[win_idx]  : '0;
            bus.core_opcode <= any_grant ? op_a[win_idx]  : '0;

            case (state)
                IDLE: begin
                    if (any_grant) begin
                        rr_ptr <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                        if (win_is_load) begin
                            state    <= LOAD_WAIT;
                            busy     <= 1'b1;
                            wait_cnt <= '0;
                        end
                    end
                end
                LOAD_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // Data return takes priority over a coincident timeout.
                    if (bus.core_data_valid) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef RISCV_ISSUE_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (any_grant && issue_cnt != 16'hFFFF) begin
                issue_cnt <= issue_cnt + 16'd1;
            end
            if ((|bus.req_valid) && !any_grant && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_riscv_issue_arb.sv
// tb_riscv_issue_arb
// Bench for riscv_issue_arb (NUM_REQ=4, REG_WIDTH=5, OP_WIDTH=7, TIMEOUT=15).
// Inputs are driven on the falling edge; outputs are checked 1 time unit
// later, so registered outputs reflect the preceding rising edge.
// Honours RISCV_ISSUE_ARB_STATS_EN to exercise the statistics counters.
module tb_riscv_issue_arb;

    localparam int N  = 4;
    localparam int RW = 5;
    localparam int OW = 7;
    localparam int TO = 15;

    logic clk;
    logic reset;
    logic busy;
    logic timeout_err;
`ifdef RISCV_ISSUE_ARB_STATS_EN
    logic [15:0] issue_cnt;
    logic [15:0] stall_cnt;
`endif

    riscv_issue_arb_if #(.NUM_REQ(N), .REG_WIDTH(RW), .OP_WIDTH(OW)) bus ();

    riscv_issue_arb #(
        .NUM_REQ   (N),
        .REG_WIDTH (RW),
        .OP_WIDTH  (OW),
        .TIMEOUT   (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .timeout_err (timeout_err)
`ifdef RISCV_ISSUE_ARB_STATS_EN
        ,
        .issue_cnt   (issue_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [RW-1:0] t_rs0 [N];
    logic [RW-1:0] t_rs1 [N];
    logic [RW-1:0] t_rd  [N];
    logic [OW-1:0] t_op  [N];

    typedef struct {
        logic [3:0]    valid;
        logic [3:0]    exp_grant;
        logic          exp_cv;
        logic [RW-1:0] exp_rs0;
        logic [RW-1:0] exp_rs1;
        logic [RW-1:0] exp_rd;
        logic [OW-1:0] exp_op;
    } vec_t;

    vec_t tbl [8];

    // Reference model state (spec-level: integer pointer, load flag, counter)
    int            m_ptr;
    bit            m_load;
    int            m_cnt;
    bit            m_err;
    bit            m_cv;
    logic [RW-1:0] m_rs0, m_rs1, m_rd;
    logic [OW-1:0] m_op;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [RW-1:0] rs0, input logic [RW-1:0] rs1,
                           input logic [RW-1:0] rd, input logic [OW-1:0] op);
        t_rs0[i] = rs0;
        t_rs1[i] = rs1;
        t_rd[i]  = rd;
        t_op[i]  = op;
    endtask

    task automatic drive(input logic [3:0] v, input logic dv);
        bus.req_valid       = v;
        bus.req_rs0         = {t_rs0[3], t_rs0[2], t_rs0[1], t_rs0[0]};
        bus.req_rs1         = {t_rs1[3], t_rs1[2], t_rs1[1], t_rs1[0]};
        bus.req_rd          = {t_rd[3],  t_rd[2],  t_rd[1],  t_rd[0]};
        bus.req_opcode      = {t_op[3],  t_op[2],  t_op[1],  t_op[0]};
        bus.core_data_valid = dv;
    endtask

    // One cycle: apply inputs at the falling edge, settle, caller then checks.
    task automatic step(input logic [3:0] v, input logic dv);
        @(negedge clk);
        drive(v, dv);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic cv,
                           input logic [RW-1:0] rs0, input logic [RW-1:0] rs1,
                           input logic [RW-1:0] rd, input logic [OW-1:0] op,
                           input logic bz, input logic er);
        chk({tag, ".grant"},  bus.req_grant,   g);
        chk({tag, ".cvalid"}, bus.core_valid,  cv);
        chk({tag, ".rs0"},    bus.core_rs0,    rs0);
        chk({tag, ".rs1"},    bus.core_rs1,    rs1);
        chk({tag, ".rd"},     bus.core_rd,     rd);
        chk({tag, ".op"},     bus.core_opcode, op);
        chk({tag, ".busy"},   busy,            bz);
        chk({tag, ".terr"},   timeout_err,     er);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(4'b0000, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic model_reset();
        m_ptr = 0; m_load = 0; m_cnt = 0; m_err = 0; m_cv = 0;
        m_rs0 = '0; m_rs1 = '0; m_rd = '0; m_op = '0;
    endtask

    task automatic default_fields();
        set_req(0, 5'd8,  5'd16, 5'd24, 7'h33);
        set_req(1, 5'd9,  5'd17, 5'd25, 7'h33);
        set_req(2, 5'd3,  5'd4,  5'd5,  7'h13);
        set_req(3, 5'd11, 5'd19, 5'd27, 7'h33);
    endtask

    initial begin
        logic [3:0] v;
        logic       dv;
        logic [3:0] eg;
        int         w;

        reset = 1'b1;
        default_fields();
        drive(4'b0000, 1'b0);

        // Round-robin over all four, then single-requester issue latency.
        tbl[0] = '{4'b1111, 4'b0001, 1'b0, 5'd0,  5'd0,  5'd0,  7'h00};
        tbl[1] = '{4'b1111, 4'b0010, 1'b1, 5'd8,  5'd16, 5'd24, 7'h33};
        tbl[2] = '{4'b1111, 4'b0100, 1'b1, 5'd9,  5'd17, 5'd25, 7'h33};
        tbl[3] = '{4'b1111, 4'b1000, 1'b1, 5'd3,  5'd4,  5'd5,  7'h13};
        tbl[4] = '{4'b1111, 4'b0001, 1'b1, 5'd11, 5'd19, 5'd27, 7'h33};
        tbl[5] = '{4'b0100, 4'b0100, 1'b1, 5'd8,  5'd16, 5'd24, 7'h33};
        tbl[6] = '{4'b0000, 4'b0000, 1'b1, 5'd3,  5'd4,  5'd5,  7'h13};
        tbl[7] = '{4'b0000, 4'b0000, 1'b0, 5'd0,  5'd0,  5'd0,  7'h00};

        // Held in reset with every request up: nothing may leak out.
        step(4'b1111, 1'b0);
        chk_all("reset", 4'b0000, 1'b0, 5'd0, 5'd0, 5'd0, 7'h00, 1'b0, 1'b0);

        @(negedge clk);
        reset = 1'b0;
        drive(tbl[0].valid, 1'b0);
        #1;
        for (int unsigned r = 0; r < 8; r++) begin
            if (r != 0) step(tbl[r].valid, 1'b0);
            chk_all($sformatf("tbl%0d", r), tbl[r].exp_grant, tbl[r].exp_cv, tbl[r].exp_rs0,
                    tbl[r].exp_rs1, tbl[r].exp_rd, tbl[r].exp_op, 1'b0, 1'b0);
        end

        // Load from req1 with req3 pending; data returns on the 4th cycle after issue.
        set_req(1, 5'd9, 5'd17, 5'd25, 7'h00);
        step(4'b0010, 1'b0);
        chk("ld.grant", bus.req_grant, 4'b0010);
        for (int unsigned c = 0; c < 4; c++) begin
            step(4'b1000, (c == 3) ? 1'b1 : 1'b0);
            chk($sformatf("ld.wait%0d.grant", c), bus.req_grant, 4'b0000);
            chk($sformatf("ld.wait%0d.busy", c), busy, 1'b1);
        end
        step(4'b1000, 1'b0);
        chk("ld.done.busy", busy, 1'b0);
        chk("ld.done.grant", bus.req_grant, 4'b1000);
        step(4'b0000, 1'b0);
        chk_all("ld.issue3", 4'b0000, 1'b1, 5'd11, 5'd19, 5'd27, 7'h33, 1'b0, 1'b0);
        set_req(1, 5'd9, 5'd17, 5'd25, 7'h33);

        // Data arriving on the final LOAD_WAIT cycle beats the timeout.
        set_req(0, 5'd8, 5'd16, 5'd24, 7'h00);
        step(4'b0001, 1'b0);
        chk("dw.grant", bus.req_grant, 4'b0001);
        for (int unsigned c = 0; c < TO; c++) begin
            step(4'b0100, (c == TO - 1) ? 1'b1 : 1'b0);
            chk($sformatf("dw.wait%0d.busy", c), busy, 1'b1);
        end
        step(4'b0100, 1'b0);
        chk("dw.done.busy", busy, 1'b0);
        chk("dw.done.terr", timeout_err, 1'b0);
        chk("dw.done.grant", bus.req_grant, 4'b0100);
        set_req(0, 5'd8, 5'd16, 5'd24, 7'h33);
        step(4'b0000, 1'b0);

        // Timeout: req1 load, no data for TIMEOUT cycles.
        set_req(1, 5'd9, 5'd17, 5'd25, 7'h00);
        step(4'b0010, 1'b0);
        chk("to.grant", bus.req_grant, 4'b0010);
        for (int unsigned c = 0; c < TO; c++) begin
            step(4'b0100, 1'b0);
            chk($sformatf("to.wait%0d.busy", c), busy, 1'b1);
            chk($sformatf("to.wait%0d.terr", c), timeout_err, 1'b0);
            chk($sformatf("to.wait%0d.grant", c), bus.req_grant, 4'b0000);
        end
        step(4'b0100, 1'b0);
        chk("to.done.busy", busy, 1'b0);
        chk("to.done.terr", timeout_err, 1'b1);
        chk("to.done.grant", bus.req_grant, 4'b0100);
        step(4'b0000, 1'b0);
        chk_all("to.after", 4'b0000, 1'b1, 5'd3, 5'd4, 5'd5, 7'h13, 1'b0, 1'b1);

        // Reset in the middle of LOAD_WAIT (rr_ptr is 2 at that point).
        step(4'b0010, 1'b0);
        chk("rst.ld.grant", bus.req_grant, 4'b0010);
        step(4'b1000, 1'b0);
        chk("rst.ld.busy", busy, 1'b1);
        set_req(1, 5'd9, 5'd17, 5'd25, 7'h33);
        @(negedge clk);
        reset = 1'b1;
        drive(4'b1111, 1'b0);
        #1;
        chk_all("rst.mid", 4'b0000, 1'b0, 5'd0, 5'd0, 5'd0, 7'h00, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst.rel.grant", bus.req_grant, 4'b0001);

`ifdef RISCV_ISSUE_ARB_STATS_EN
        // 3 grants (last one a load) then 5 blocked cycles.
        do_reset();
        default_fields();
        set_req(2, 5'd3, 5'd4, 5'd5, 7'h00);
        step(4'b0001, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0100, 1'b0);
        for (int unsigned c = 0; c < 5; c++) step(4'b1000, (c == 4) ? 1'b1 : 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        chk("stats.issue", issue_cnt, 16'd3);
        chk("stats.stall", stall_cnt, 16'd5);
`endif

        // Randomised traffic against the reference model.
        do_reset();
        model_reset();
        for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
            v  = 4'($urandom_range(0, 15));
            dv = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < N; i++) begin
                t_rs0[i] = RW'($urandom);
                t_rs1[i] = RW'($urandom);
                t_rd[i]  = RW'($urandom);
                t_op[i]  = ($urandom_range(0, 3) == 0) ? 7'h00 : OW'($urandom_range(1, 127));
            end
            @(negedge clk);
            drive(v, dv);
            #1;

            w = -1;
            if (!m_load) begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (w < 0 && v[j]) w = j;
                end
            end
            eg = (w >= 0) ? 4'(1 << w) : 4'b0000;
            chk_all("rand", eg, m_cv, m_rs0, m_rs1, m_rd, m_op, m_load, m_err);

            // Advance the model across the coming rising edge.
            m_cv = (w >= 0);
            if (w >= 0) begin
                m_rs0 = t_rs0[w]; m_rs1 = t_rs1[w]; m_rd = t_rd[w]; m_op = t_op[w];
                m_ptr = (w + 1) % N;
                if (t_op[w] == 7'h00) begin
                    m_load = 1;
                    m_cnt  = 0;
                end
            end else begin
                m_rs0 = '0; m_rs1 = '0; m_rd = '0; m_op = '0;
                if (m_load) begin
                    if (dv) begin
                        m_load = 0;
                    end else if (m_cnt == TO - 1) begin
                        m_load = 0;
                        m_err  = 1;
                    end else begin
                        m_cnt++;
                    end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
